// File: rtl/score_table_ctrl.sv
// rtl/score_table_ctrl.sv - arbiter/sequencer for the per-user score RAM with keep-best store and high-score scan
module score_table_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              clear_ack,
    input  logic              store_req,
    input  logic [ADDR_W-1:0] store_id,
    input  logic [DATA_W-1:0] store_score,
    output logic              store_ack,
    output logic              store_wrote,
    input  logic              scan_req,
    output logic              scan_ack,
    output logic [DATA_W-1:0] high_score,
    output logic [ADDR_W-1:0] high_id,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_id,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [3:0] {
        IDLE, CLR, ST_RD, ST_CMP, SC_RUN, SC_DONE, RD_A, RD_D, RD_DONE
    } state_t;

    // Last table entry (clear end) and the extra scan cycle that consumes entry 7's read data.
    localparam logic [ADDR_W:0] K_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] K_END  = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W:0]   k;
    logic [ADDR_W-1:0] op_id;
    logic [DATA_W-1:0] op_score;
    logic [DATA_W-1:0] run_max;
    logic [ADDR_W-1:0] run_id;
    logic              store_better;
    logic              scan_gt;
    logic [ADDR_W-1:0] scan_id;

    // Read data in ST_CMP is the stored entry; strict compare makes ties keep the old score.
    assign store_better = (state == ST_CMP) && (op_score > ram_rdata);
    // During scan, ram_rdata belongs to the entry addressed one cycle earlier (k-1).
    assign scan_gt      = ram_rdata > run_max;
    assign scan_id      = k[ADDR_W-1:0] - ADDR_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: fixed-priority acceptance in IDLE, fixed-length sequences elsewhere
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (clear_req)      state_nx = CLR;
                else if (store_req) state_nx = ST_RD;
                else if (scan_req)  state_nx = SC_RUN;
                else if (rd_req)    state_nx = RD_A;
            end
            CLR:     if (k == K_LAST) state_nx = IDLE;
            ST_RD:   state_nx = ST_CMP;
            ST_CMP:  state_nx = IDLE;
            SC_RUN:  if (k == K_END) state_nx = SC_DONE;
            SC_DONE: state_nx = IDLE;
            RD_A:    state_nx = RD_D;
            RD_D:    state_nx = RD_DONE;
            RD_DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, sequence counter, running max and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            op_id      <= '0;
            op_score   <= '0;
            run_max    <= '0;
            run_id     <= '0;
            high_score <= '0;
            high_id    <= '0;
            rd_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    k       <= '0;
                    run_max <= '0;
                    run_id  <= '0;
                    if (state_nx == ST_RD) begin
                        op_id    <= store_id;
                        op_score <= store_score;
                    end else if (state_nx == RD_A) begin
                        op_id <= rd_id;
                    end
                end
                CLR: begin
                    k <= k + 1'b1;
                    if (k == K_LAST) begin
                        k          <= '0;
                        high_score <= '0;
                        high_id    <= '0;
                    end
                end
                ST_CMP: begin
                    // Keep the cached maximum current so a scan is not needed after each store.
                    if (store_better && (op_score > high_score)) begin
                        high_score <= op_score;
                        high_id    <= op_id;
                    end
                end
                SC_RUN: begin
                    k <= k + 1'b1;
                    if ((k != '0) && scan_gt) begin
                        run_max <= ram_rdata;
                        run_id  <= scan_id;
                    end
                    if (k == K_END) begin
                        k          <= '0;
                        high_score <= scan_gt ? ram_rdata : run_max;
                        high_id    <= scan_gt ? scan_id : run_id;
                    end
                end
                RD_D: begin
                    rd_data <= ram_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: RAM port, acks and status decoded from state
    always_comb begin
        ram_addr    = '0;
        ram_wdata   = '0;
        ram_we      = 1'b0;
        clear_ack   = 1'b0;
        store_ack   = 1'b0;
        store_wrote = 1'b0;
        scan_ack    = 1'b0;
        rd_ack      = 1'b0;
        busy        = (state != IDLE);
        case (state)
            CLR: begin
                ram_addr  = k[ADDR_W-1:0];
                ram_we    = 1'b1;
                clear_ack = (k == K_LAST);
            end
            ST_RD: begin
                ram_addr = op_id;
            end
            ST_CMP: begin
                ram_addr    = op_id;
                ram_wdata   = op_score;
                ram_we      = store_better;
                store_wrote = store_better;
                store_ack   = 1'b1;
            end
            SC_RUN: begin
                ram_addr = k[ADDR_W-1:0];
            end
            SC_DONE: begin
                scan_ack = 1'b1;
            end
            RD_A: begin
                ram_addr = op_id;
            end
            RD_DONE: begin
                rd_ack = 1'b1;
            end
            default: begin
            end
        endcase
        // Reset must never let a write reach the RAM, even before state is known.
        if (rst) begin
            ram_we = 1'b0;
        end
    end

endmodule
